// File: rtl/seven_seg_scanner_if.sv
// Display-side signal bundle for the seven-segment scanner: value/mode in, segment drive out.
interface seven_seg_scanner_if;
  logic [14:0] value;
  logic        dec_mode;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  modport master (output value, dec_mode, input seg, an, dp, busy);
  modport slave  (input value, dec_mode, output seg, an, dp, busy);
endinterface

// File: rtl/seven_seg_scanner.sv
// Basys3 4-digit seven-segment scanner: hex or sequential double-dabble decimal display,
// with the digit buffer refreshed atomically once per full scan.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int WIDTH       = 15
) (
  input logic                clk,
  input logic                reset,
  seven_seg_scanner_if.slave bus
);
  localparam int         CNT_W = $clog2(REFRESH_DIV);
  localparam int         BCD_W = 20;
  localparam int         SR_W  = BCD_W + WIDTH;
  localparam logic [4:0] DASH  = 5'h10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0][4:0]  disp;
  logic [SR_W-1:0]  sr;
  logic [3:0]       iter;
  logic             hex_vld_p0;
  logic [WIDTH-1:0] hex_val_p0;
  logic [15:0]      hex16;
  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic             dp_r;
  logic             busy_r;
  logic             tick;
  logic             capture;

  assign tick    = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign capture = tick && (idx == 2'd3);
  assign hex16   = 16'(hex_val_p0);

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.dp   = dp_r;
  assign bus.busy = busy_r;

  // Digit code 0..15 is a hex nibble; DASH marks decimal overflow.
  function automatic logic [6:0] encode(input logic [4:0] d);
    case (d)
      5'h00:   return 7'b1000000;
      5'h01:   return 7'b1111001;
      5'h02:   return 7'b0100100;
      5'h03:   return 7'b0110000;
      5'h04:   return 7'b0011001;
      5'h05:   return 7'b0010010;
      5'h06:   return 7'b0000010;
      5'h07:   return 7'b1111000;
      5'h08:   return 7'b0000000;
      5'h09:   return 7'b0010000;
      5'h0A:   return 7'b0001000;
      5'h0B:   return 7'b0000011;
      5'h0C:   return 7'b1000110;
      5'h0D:   return 7'b0100001;
      5'h0E:   return 7'b0000110;
      5'h0F:   return 7'b0001110;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (t[WIDTH + 4*k +: 4] >= 4'd5)
        t[WIDTH + 4*k +: 4] = t[WIDTH + 4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 2'd0;
      state      <= IDLE;
      disp       <= '0;
      iter       <= 4'd0;
      hex_vld_p0 <= 1'b0;
      an_r       <= 4'b1110;
      seg_r      <= 7'b1000000;
      dp_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;

      an_r  <= ~(4'b0001 << idx);
      seg_r <= encode(disp[idx]);
      dp_r  <= 1'b1;

      // Stage p0: hex capture is registered, then committed to the buffer a cycle later.
      hex_vld_p0 <= capture && !bus.dec_mode && (state == IDLE);
      hex_val_p0 <= bus.value;
      if (hex_vld_p0) begin
        disp[3] <= {1'b0, hex16[15:12]};
        disp[2] <= {1'b0, hex16[11:8]};
        disp[1] <= {1'b0, hex16[7:4]};
        disp[0] <= {1'b0, hex16[3:0]};
      end

      case (state)
        IDLE: begin
          if (capture && bus.dec_mode) begin
            sr     <= SR_W'(bus.value);
            iter   <= 4'd0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sr   <= dabble_step(sr);
          iter <= iter + 4'd1;
          if (iter == 4'(WIDTH - 1))
            state <= DONE;
        end
        DONE: begin
          // A non-zero ten-thousands digit cannot be shown on four digits.
          if (sr[SR_W-1 -: 4] != 4'd0) begin
            disp <= {DASH, DASH, DASH, DASH};
          end else begin
            disp[3] <= {1'b0, sr[WIDTH + 12 +: 4]};
            disp[2] <= {1'b0, sr[WIDTH + 8 +: 4]};
            disp[1] <= {1'b0, sr[WIDTH + 4 +: 4]};
            disp[0] <= {1'b0, sr[WIDTH +: 4]};
          end
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
